// File: rtl/tpu_pkg.sv
// tpu_pkg: FSM states and accumulator shift/saturate helper shared by PU variants.
package tpu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  // Returns {clamped_flag, value}; caller keeps the low dw bits of value.
  function automatic logic [128:0] shift_sat(input logic signed [127:0] acc, input int shift, input int dw, input logic sat_en);
    logic signed [127:0] s, hi, lo;
    s = acc >>> shift;
    hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    return (sat_en && s > hi) ? {1'b1, hi} : (sat_en && s < lo) ? {1'b1, lo} : {1'b0, s};
  endfunction
endpackage

// File: rtl/pe_mac_cell.sv
// pe_mac_cell: one weight-stationary MAC cell with eastward activation forwarding.
module pe_mac_cell #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        en,
  input  logic                        load,
  input  logic                        zero,
  input  logic [DATA_WIDTH-1:0]       w_in,
  input  logic [DATA_WIDTH-1:0]       a_in,
  input  logic                        valid_in,
  input  logic                        last_in,
  output logic [DATA_WIDTH-1:0]       a_out,
  output logic                        valid_out,
  output logic                        last_out,
  output logic signed [ACC_WIDTH-1:0] acc
);
  logic signed [DATA_WIDTH-1:0]   w;
  logic signed [2*DATA_WIDTH-1:0] prod;
  assign prod = $signed(a_in) * w;
  always_ff @(posedge clk)
    if (reset) begin
      w         <= '0;
      a_out     <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      acc       <= '0;
    end else if (clear) begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      acc       <= '0;
    end else if (en) begin
      if (load) w <= w_in;
      a_out     <= a_in;
      valid_out <= valid_in;
      last_out  <= last_in & valid_in;
      acc       <= zero ? '0 : valid_in ? acc + ACC_WIDTH'(prod) : acc;
    end
endmodule

// File: rtl/systolic_pe_row.sv
// systolic_pe_row: weight-stationary 1-D systolic MAC row with flush FSM and narrowed outputs.
module systolic_pe_row
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int NUM_PE     = 4,
  parameter int OUT_SHIFT  = 0,
  parameter int SATURATE   = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           clear,
  input  logic                           load_w,
  input  logic [NUM_PE*DATA_WIDTH-1:0]   w_in,
  input  logic                           in_valid,
  input  logic                           in_last,
  input  logic [DATA_WIDTH-1:0]          a_in,
  output logic                           in_ready,
  output logic [NUM_PE*DATA_WIDTH-1:0]   P,
  output logic                           out_valid,
  output logic [NUM_PE-1:0]              out_sat
);
  localparam int CW = $clog2(NUM_PE + 1);
  state_t                      state, nxt;
  logic [CW-1:0]               cnt;
  logic                        accept, fire, wload;
  logic [DATA_WIDTH-1:0]       a_c [NUM_PE+1];
  logic                        v_c [NUM_PE+1];
  logic                        l_c [NUM_PE+1];
  logic signed [ACC_WIDTH-1:0] acc [NUM_PE];
  logic [128:0]                nar [NUM_PE];
  assign in_ready = state == IDLE || state == RUN;
  assign accept   = in_valid & in_ready & en;
  assign wload    = load_w & (state == IDLE) & ~in_valid;
  // The last sample leaving the final PE marks the edge where every accumulator is complete.
  assign fire     = en & v_c[NUM_PE] & l_c[NUM_PE];
  assign a_c[0]   = a_in;
  assign v_c[0]   = accept;
  assign l_c[0]   = in_last;
  for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
    pe_mac_cell #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_cell (
      .clk(clk),
      .reset(reset),
      .clear(clear),
      .en(en),
      .load(wload),
      .zero(fire),
      .w_in(w_in[k*DATA_WIDTH +: DATA_WIDTH]),
      .a_in(a_c[k]),
      .valid_in(v_c[k]),
      .last_in(l_c[k]),
      .a_out(a_c[k+1]),
      .valid_out(v_c[k+1]),
      .last_out(l_c[k+1]),
      .acc(acc[k])
    );
    assign nar[k] = shift_sat(128'(acc[k]), OUT_SHIFT, DATA_WIDTH, SATURATE != 0);
  end
  always_comb
    nxt = ((state == IDLE || state == RUN) && accept) ? (in_last ? (NUM_PE == 1 ? DONE : FLUSH) : RUN)
        : (state == FLUSH && int'(cnt) == NUM_PE - 2) ? DONE
        : (state == DONE) ? IDLE
        : state;
  always_ff @(posedge clk)
    if (reset || clear) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (en) begin
      state <= nxt;
      cnt   <= state == FLUSH ? cnt + 1'b1 : '0;
    end
  always_ff @(posedge clk)
    if (reset) begin
      P         <= '0;
      out_sat   <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= fire;
      if (fire)
        for (int k = 0; k < NUM_PE; k++) begin
          P[k*DATA_WIDTH +: DATA_WIDTH] <= nar[k][DATA_WIDTH-1:0];
          out_sat[k]                    <= nar[k][128];
        end
    end
endmodule
